// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand-issue and writeback stage around an external 8-bit ALU.
// The stage holds an 8 x 8-bit register file and latches one decoded instruction
// into an EX register that drives the ALU. The ALU result is written back on the
// next advancing edge. The in-flight result is forwarded to the next instruction,
// so dependent back-to-back instructions do not stall.
module alu_issue_stage #(
    parameter int UUID  = 0,
    parameter     NAME  = "",
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_op,
    input  logic [2:0]       in_src1,
    input  logic [2:0]       in_src2,
    input  logic             in_use_imm,
    input  logic [7:0]       in_imm,
    input  logic [2:0]       in_dst,
    input  logic             hold,
    output logic [7:0]       alu_instr,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    input  logic [7:0]       alu_result,
    output logic             ex_valid,
    input  logic [2:0]       rd_addr,
    output logic [7:0]       rd_data,
    output logic [CNT_W-1:0] retired
);

    // UUID and NAME only identify the instance; fold them into a sink signal.
    logic [31:0] unused_id_s;
    assign unused_id_s = UUID ^ $bits(NAME);

    logic [7:0] regs_r [8];
    logic [2:0] ex_dst_r;
    logic [7:0] op_a_s;
    logic [7:0] op_b_s;
    logic       advance_s;

    // Register 0 is hard zero; otherwise use the in-flight result when it
    // targets the same non-zero register, else the register file value.
    function automatic logic [7:0] pick_operand(
        input logic [2:0] idx,
        input logic [7:0] reg_val,
        input logic       fwd_valid,
        input logic [2:0] fwd_dst,
        input logic [7:0] fwd_val
    );
        logic [7:0] val;
        if (idx == 3'd0) begin
            val = 8'h00;
        end else if (fwd_valid && (fwd_dst != 3'd0) && (idx == fwd_dst)) begin
            val = fwd_val;
        end else begin
            val = reg_val;
        end
        return val;
    endfunction

    assign in_ready  = ~hold;
    assign advance_s = ~hold;

    // Select operands A and B for the instruction offered on the input side.
    always_comb begin
        op_a_s = pick_operand(in_src1, regs_r[in_src1], ex_valid, ex_dst_r, alu_result);
        if (in_use_imm) begin
            op_b_s = in_imm;
        end else begin
            op_b_s = pick_operand(in_src2, regs_r[in_src2], ex_valid, ex_dst_r, alu_result);
        end
    end

    // Debug read port: returns the current (pre-edge) register value.
    always_comb begin
        if (rd_addr == 3'd0) begin
            rd_data = 8'h00;
        end else begin
            rd_data = regs_r[rd_addr];
        end
    end

    // EX register: load on an advancing edge with a valid instruction, keep
    // operands unchanged otherwise so the ALU output stays stable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid  <= 1'b0;
            alu_instr <= 8'h00;
            alu_a     <= 8'h00;
            alu_b     <= 8'h00;
            ex_dst_r  <= 3'd0;
        end else if (advance_s) begin
            if (in_valid) begin
                ex_valid  <= 1'b1;
                alu_instr <= in_op;
                alu_a     <= op_a_s;
                alu_b     <= op_b_s;
                ex_dst_r  <= in_dst;
            end else begin
                ex_valid  <= 1'b0;
            end
        end else begin
            ex_valid <= ex_valid;
        end
    end

    // Register file writeback of the EX result; writes to register 0 are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else if (advance_s && ex_valid && (ex_dst_r != 3'd0)) begin
            regs_r[ex_dst_r] <= alu_result;
        end else begin
            regs_r[0] <= 8'h00;
        end
    end

    // Retired-instruction counter, wraps modulo 2^CNT_W; dst=0 still counts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired <= {CNT_W{1'b0}};
        end else if (advance_s && ex_valid) begin
            retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retired <= retired;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed scenarios plus randomized traffic,
// checked against an architectural model (register array + one pending op).
module tb_alu_issue_stage;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_op;
    logic [2:0] in_src1;
    logic [2:0] in_src2;
    logic       in_use_imm;
    logic [7:0] in_imm;
    logic [2:0] in_dst;
    logic       hold;
    logic [2:0] rd_addr;

    logic        in_ready;
    logic [7:0]  alu_instr, alu_a, alu_b, alu_result, rd_data;
    logic        ex_valid;
    logic [15:0] retired;

    logic        s_in_ready;
    logic [7:0]  s_alu_instr, s_alu_a, s_alu_b, s_alu_result, s_rd_data;
    logic        s_ex_valid;
    logic [3:0]  s_retired;

    int checks = 0;
    int errors = 0;

    // Architectural model state
    logic [7:0]  m_regs [8];
    logic        m_exv;
    logic [7:0]  m_op, m_a, m_b;
    logic [2:0]  m_dst;
    logic [15:0] m_ret;

    // Simple ALU: low two opcode bits pick add / sub / and / xor
    function automatic logic [7:0] alu_fn(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op[1:0])
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_result   = alu_fn(alu_instr, alu_a, alu_b);
    assign s_alu_result = alu_fn(s_alu_instr, s_alu_a, s_alu_b);

    alu_issue_stage #(.UUID(1), .NAME("main"), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2),
        .in_use_imm(in_use_imm), .in_imm(in_imm), .in_dst(in_dst), .hold(hold),
        .alu_instr(alu_instr), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .ex_valid(ex_valid), .rd_addr(rd_addr), .rd_data(rd_data), .retired(retired)
    );

    alu_issue_stage #(.UUID(2), .NAME("narrow"), .CNT_W(4)) dut_narrow (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2),
        .in_use_imm(in_use_imm), .in_imm(in_imm), .in_dst(in_dst), .hold(hold),
        .alu_instr(s_alu_instr), .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_result(s_alu_result),
        .ex_valid(s_ex_valid), .rd_addr(rd_addr), .rd_data(s_rd_data), .retired(s_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_exv = 1'b0; m_op = 8'h00; m_a = 8'h00; m_b = 8'h00; m_dst = 3'd0; m_ret = 16'h0000;
    endtask

    // Architectural view: finish the pending op, then read operands from the
    // updated register array (this is what forwarding must reproduce).
    task automatic model_edge();
        if (!hold) begin
            if (m_exv) begin
                if (m_dst != 3'd0) m_regs[m_dst] = alu_fn(m_op, m_a, m_b);
                m_ret = m_ret + 16'd1;
            end
            if (in_valid) begin
                m_op  = in_op;
                m_a   = m_regs[in_src1];
                m_b   = in_use_imm ? in_imm : m_regs[in_src2];
                m_dst = in_dst;
                m_exv = 1'b1;
            end else begin
                m_exv = 1'b0;
            end
        end
    endtask

    // One clock: rising edge updates the model, return at the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (!rst) model_reset();
        else model_edge();
        @(negedge clk);
    endtask

    task automatic issue(input logic [7:0] op, input logic [2:0] s1, input logic [2:0] s2,
                         input logic ui, input logic [7:0] imm, input logic [2:0] dst);
        in_valid = 1'b1; in_op = op; in_src1 = s1; in_src2 = s2;
        in_use_imm = ui; in_imm = imm; in_dst = dst;
    endtask

    task automatic test_reset();
        rst = 1'b0; hold = 1'b0; in_valid = 1'b0; rd_addr = 3'd0;
        in_op = 8'h00; in_src1 = 3'd0; in_src2 = 3'd0; in_use_imm = 1'b0; in_imm = 8'h00; in_dst = 3'd0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rd_addr = k[2:0]; #1;
            checks++;
            if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_reg%0d: got %0h expected 00", k, rd_data); end
        end
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %0b expected 0", ex_valid); end
        checks++;
        if (retired !== 16'h0000) begin errors++; $display("FAIL reset_retired: got %0h expected 0", retired); end
        checks++;
        if ({alu_instr, alu_a, alu_b} !== 24'h0) begin errors++; $display("FAIL reset_alu: got %0h expected 0", {alu_instr, alu_a, alu_b}); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    endtask

    task automatic test_forward();
        issue(8'h00, 3'd0, 3'd0, 1'b1, 8'd5, 3'd1);
        cycle();
        issue(8'h00, 3'd1, 3'd0, 1'b1, 8'd3, 3'd2);
        cycle();
        checks++;
        if (alu_a !== 8'd5) begin errors++; $display("FAIL fwd_alu_a: got %0h expected 05", alu_a); end
        checks++;
        if (alu_b !== 8'd3) begin errors++; $display("FAIL fwd_alu_b: got %0h expected 03", alu_b); end
        in_valid = 1'b0;
        cycle();
        rd_addr = 3'd1; #1;
        checks++;
        if (rd_data !== 8'd5) begin errors++; $display("FAIL fwd_reg1: got %0h expected 05", rd_data); end
        rd_addr = 3'd2; #1;
        checks++;
        if (rd_data !== 8'd8) begin errors++; $display("FAIL fwd_reg2: got %0h expected 08", rd_data); end
        checks++;
        if (retired !== 16'd2) begin errors++; $display("FAIL fwd_retired: got %0h expected 2", retired); end
    endtask

    task automatic test_hold();
        logic [15:0] ret0;
        logic [7:0]  reg3_0;
        issue(8'h00, 3'd2, 3'd0, 1'b1, 8'h22, 3'd3);
        cycle();
        ret0 = m_ret; reg3_0 = m_regs[3];
        hold = 1'b1;
        issue(8'h01, 3'd1, 3'd2, 1'b0, 8'h00, 3'd4);
        rd_addr = 3'd3;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready: got %0b expected 0", in_ready); end
            checks++;
            if (rd_data !== reg3_0) begin errors++; $display("FAIL hold_reg3: got %0h expected %0h", rd_data, reg3_0); end
            checks++;
            if (retired !== ret0) begin errors++; $display("FAIL hold_retired: got %0h expected %0h", retired, ret0); end
            checks++;
            if (ex_valid !== 1'b1 || alu_a !== 8'd8 || alu_b !== 8'h22) begin
                errors++; $display("FAIL hold_ex: got v=%0b a=%0h b=%0h expected v=1 a=08 b=22", ex_valid, alu_a, alu_b);
            end
        end
        hold = 1'b0; in_valid = 1'b0;
        cycle();
        checks++;
        if (rd_data !== 8'h2A) begin errors++; $display("FAIL hold_release_reg3: got %0h expected 2a", rd_data); end
        checks++;
        if (retired !== ret0 + 16'd1) begin errors++; $display("FAIL hold_release_retired: got %0h expected %0h", retired, ret0 + 16'd1); end
    endtask

    task automatic test_dst_zero();
        logic [15:0] ret0;
        ret0 = m_ret;
        issue(8'h00, 3'd0, 3'd0, 1'b1, 8'hFF, 3'd0);
        cycle();
        checks++;
        if (alu_result !== 8'hFF) begin errors++; $display("FAIL dst0_result: got %0h expected ff", alu_result); end
        issue(8'h00, 3'd0, 3'd0, 1'b1, 8'h01, 3'd5);
        cycle();
        checks++;
        if (alu_a !== 8'h00) begin errors++; $display("FAIL dst0_no_forward: got %0h expected 00", alu_a); end
        rd_addr = 3'd0; #1;
        checks++;
        if (rd_data !== 8'h00) begin errors++; $display("FAIL dst0_reg0: got %0h expected 00", rd_data); end
        checks++;
        if (retired !== ret0 + 16'd1) begin errors++; $display("FAIL dst0_retired: got %0h expected %0h", retired, ret0 + 16'd1); end
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_async_reset();
        issue(8'h00, 3'd0, 3'd0, 1'b1, 8'd7, 3'd4);
        cycle();
        issue(8'h00, 3'd0, 3'd0, 1'b1, 8'd9, 3'd4);
        cycle();
        rd_addr = 3'd4; #1;
        checks++;
        if (rd_data !== 8'd7 || ex_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: got reg4=%0h v=%0b expected 07 1", rd_data, ex_valid); end
        #1 rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL areset_ex_valid: got %0b expected 0", ex_valid); end
        checks++;
        if (rd_data !== 8'h00) begin errors++; $display("FAIL areset_reg4: got %0h expected 00", rd_data); end
        checks++;
        if (retired !== 16'h0000) begin errors++; $display("FAIL areset_retired: got %0h expected 0", retired); end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cycle();
        checks++;
        if (rd_data !== 8'h00 || retired !== 16'h0000) begin
            errors++; $display("FAIL areset_no_writeback: got reg4=%0h ret=%0h expected 00 0", rd_data, retired);
        end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 16; k++) begin
            issue(8'h00, 3'd0, 3'd0, 1'b1, k[7:0], 3'd6);
            cycle();
        end
        checks++;
        if (s_retired !== 4'd15) begin errors++; $display("FAIL wrap_pre: got %0h expected f", s_retired); end
        in_valid = 1'b0;
        cycle();
        checks++;
        if (s_retired !== 4'd0) begin errors++; $display("FAIL wrap_narrow: got %0h expected 0", s_retired); end
        checks++;
        if (retired !== 16'd16) begin errors++; $display("FAIL wrap_main: got %0h expected 10", retired); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            hold = ($urandom_range(0, 4) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_op = 8'($urandom); in_src1 = 3'($urandom); in_src2 = 3'($urandom);
            in_use_imm = 1'($urandom); in_imm = 8'($urandom); in_dst = 3'($urandom);
            rd_addr = 3'($urandom);
            cycle();
            checks++;
            if (in_ready !== ~hold) begin errors++; $display("FAIL rnd_in_ready: got %0b expected %0b", in_ready, ~hold); end
            checks++;
            if (ex_valid !== m_exv) begin errors++; $display("FAIL rnd_ex_valid n=%0d: got %0b expected %0b", n, ex_valid, m_exv); end
            checks++;
            if ({alu_instr, alu_a, alu_b} !== {m_op, m_a, m_b}) begin
                errors++; $display("FAIL rnd_alu n=%0d: got %0h expected %0h", n, {alu_instr, alu_a, alu_b}, {m_op, m_a, m_b});
            end
            checks++;
            if (rd_data !== m_regs[rd_addr]) begin errors++; $display("FAIL rnd_rd n=%0d r%0d: got %0h expected %0h", n, rd_addr, rd_data, m_regs[rd_addr]); end
            checks++;
            if (retired !== m_ret || s_retired !== m_ret[3:0]) begin
                errors++; $display("FAIL rnd_retired n=%0d: got %0h/%0h expected %0h/%0h", n, retired, s_retired, m_ret, m_ret[3:0]);
            end
        end
        hold = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_hold();
        test_dst_zero();
        test_async_reset();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
